// File: rtl/pdm_mem_writer_pkg.sv
// Shared definitions for the PDM memory writer: FSM states, ctrl bit
// positions and parameter defaults.
package pdm_mem_writer_pkg;

    localparam int unsigned DEFAULT_BOUND      = 46875;
    localparam int unsigned DEFAULT_ADDR_W     = 16;
    localparam int unsigned DEFAULT_FIFO_DEPTH = 4;
    localparam int unsigned DATA_W             = 32;

    // ctrl bit positions
    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_CLEAR = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // RUN and DRAIN are the states in which a capture is in progress
    function automatic logic is_busy(input state_t s);
        return (s == ST_RUN) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/pdm_word_fifo.sv
// Small synchronous FIFO for PDM words with a registered head.
// Ports:
//   ahb_clk, rst  : clock, synchronous active-high reset
//   flush         : synchronous flush (same effect as reset)
//   push, wdata   : write one word (taken when not full or popping)
//   pop           : remove the head word (ignored when empty)
//   full, empty   : registered occupancy flags
//   empty_nxt_c   : combinational "empty after this edge"
//   head          : registered oldest word (zero after reset/flush)
module pdm_word_fifo #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WIDTH      = 32
) (
    input  logic             ahb_clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic             empty_nxt_c,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d, count_left;
    logic [WIDTH-1:0] head_d;
    logic             push_ok, pop_ok;

    // Next pointers, occupancy and head word
    always_comb begin
        pop_ok     = pop & (count_q != '0);
        push_ok    = push & ((count_q != CNT_W'(FIFO_DEPTH)) | pop_ok);
        count_left = count_q - CNT_W'(pop_ok);
        count_d    = count_left + CNT_W'(push_ok);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop_ok);
        wr_ptr_d   = wr_ptr_q + PTR_W'(push_ok);
        head_d     = head;
        // Surviving entries are already in storage; a push into an
        // otherwise empty FIFO bypasses storage straight into the head.
        if (count_left != '0) begin
            head_d = mem[rd_ptr_d];
        end else if (push_ok) begin
            head_d = wdata;
        end
        empty_nxt_c = flush | (count_d == '0);
    end

    // Control and head registers
    always_ff @(posedge ahb_clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head     <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head     <= head_d;
            full     <= (count_d == CNT_W'(FIFO_DEPTH));
            empty    <= (count_d == '0);
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge ahb_clk) begin
        if (push_ok && !flush && !rst) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/pdm_mem_writer.sv
// Buffers PDM words and writes BOUND of them to sample memory at sequential
// word addresses through a req/gnt port.
// Ports:
//   ahb_clk, rst        : clock, synchronous active-high reset
//   ctrl[0] / ctrl[1]   : start (rising edge) / clear (level, highest priority)
//   in_valid, in_data   : one-cycle word strobe and packed PDM word
//   mem_req, mem_we     : write request (identical), held until mem_gnt
//   mem_addr, mem_wdata : write address and data, stable while waiting
//   mem_gnt             : memory accepts the write
//   bsy, done, ovf      : run in progress, run complete, word dropped
//   wcount              : words written in this run
module pdm_mem_writer
    import pdm_mem_writer_pkg::*;
#(
    parameter int unsigned BOUND      = DEFAULT_BOUND,
    parameter int unsigned ADDR_W     = DEFAULT_ADDR_W,
    parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic              ahb_clk,
    input  logic              rst,
    input  logic [1:0]        ctrl,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    output logic              bsy,
    output logic              done,
    output logic              ovf,
    output logic [ADDR_W-1:0] wcount
);

    state_t            state_q, state_d;
    logic              start_q, start_edge, clear;
    logic [ADDR_W-1:0] acc_q, acc_d, acc_inc;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              ovf_d, bsy_d, done_d, mem_req_d;
    logic              push, pop, drop, flush;
    logic              fifo_full, fifo_empty, fifo_empty_nxt;

    assign clear      = ctrl[CTRL_CLEAR];
    assign start_edge = ctrl[CTRL_START] & ~start_q;

    // Only a registered request can be granted
    assign pop  = mem_req & mem_gnt;
    assign push = (state_q == ST_RUN) & in_valid & (~fifo_full | pop);
    assign drop = (state_q == ST_RUN) & in_valid & ~push;

    assign acc_inc = acc_q + ADDR_W'(push);

    pdm_word_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (DATA_W)
    ) u_fifo (
        .ahb_clk     (ahb_clk),
        .rst         (rst),
        .flush       (flush),
        .push        (push),
        .pop         (pop),
        .wdata       (in_data),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .empty_nxt_c (fifo_empty_nxt),
        .head        (mem_wdata)
    );

    // Next state, counters and registered output values
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        wr_ptr_d = wr_ptr_q + ADDR_W'(pop);
        ovf_d    = ovf | drop;
        flush    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d  = ST_RUN;
                    acc_d    = '0;
                    wr_ptr_d = '0;
                end
            end
            ST_RUN: begin
                acc_d = acc_inc;
                if (acc_inc == ADDR_W'(BOUND)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty && (wr_ptr_q == ADDR_W'(BOUND))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clear behaves like reset apart from start-edge sampling
        if (clear) begin
            state_d  = ST_IDLE;
            acc_d    = '0;
            wr_ptr_d = '0;
            ovf_d    = 1'b0;
            flush    = 1'b1;
        end

        bsy_d     = is_busy(state_d);
        done_d    = (state_d == ST_DONE);
        mem_req_d = is_busy(state_d) & ~fifo_empty_nxt;
    end

    // State and output registers
    always_ff @(posedge ahb_clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            start_q  <= 1'b0;
            acc_q    <= '0;
            wr_ptr_q <= '0;
            ovf      <= 1'b0;
            bsy      <= 1'b0;
            done     <= 1'b0;
            mem_req  <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= ctrl[CTRL_START];
            acc_q    <= acc_d;
            wr_ptr_q <= wr_ptr_d;
            ovf      <= ovf_d;
            bsy      <= bsy_d;
            done     <= done_d;
            mem_req  <= mem_req_d;
        end
    end

    // Pointer and write count advance together and restart together
    assign mem_addr = wr_ptr_q;
    assign wcount   = wr_ptr_q;
    assign mem_we   = mem_req;

endmodule

// File: tb/tb_pdm_mem_writer.sv
// Directed self-checking bench for pdm_mem_writer (BOUND=8, FIFO_DEPTH=4).
module tb_pdm_mem_writer;

    localparam int unsigned BOUND      = 8;
    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned FIFO_DEPTH = 4;

    logic              ahb_clk;
    logic              rst;
    logic [1:0]        ctrl;
    logic              in_valid;
    logic [31:0]       in_data;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              bsy;
    logic              done;
    logic              ovf;
    logic [ADDR_W-1:0] wcount;

    int n_checks = 0;
    int n_err    = 0;
    int req_cycles = 0;

    logic [ADDR_W-1:0] wr_addr_q [$];
    logic [31:0]       wr_data_q [$];

    pdm_mem_writer #(
        .BOUND      (BOUND),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .ahb_clk   (ahb_clk),
        .rst       (rst),
        .ctrl      (ctrl),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_gnt   (mem_gnt),
        .bsy       (bsy),
        .done      (done),
        .ovf       (ovf),
        .wcount    (wcount)
    );

    initial ahb_clk = 1'b0;
    always #5 ahb_clk = ~ahb_clk;

    // Record completed writes midway between edges
    always @(negedge ahb_clk) begin
        if (mem_req) req_cycles++;
        if (mem_req && mem_gnt) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ahb_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_word(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic start_run();
        ctrl = 2'b01;
        tick();
        ctrl = 2'b00;
    endtask

    task automatic clear_run();
        ctrl = 2'b10;
        tick();
        ctrl = 2'b00;
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60; i++) begin
            if (done) break;
            tick();
        end
        check("done_reached", 32'(done), 32'd1);
    endtask

    // Compare recorded writes against addresses 0..n-1 and data base+i
    task automatic check_writes(input string tag, input int n, input logic [31:0] base);
        check({tag, "_count"}, 32'(wr_addr_q.size()), 32'(n));
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            check({tag, "_addr"}, 32'(wr_addr_q[i]), 32'(i));
            check({tag, "_data"}, wr_data_q[i], base + 32'(i));
        end
    endtask

    initial begin
        rst      = 1'b1;
        ctrl     = 2'b00;
        in_valid = 1'b0;
        in_data  = 32'h0;
        mem_gnt  = 1'b0;
        ticks(2);

        // Reset values
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_bsy", 32'(bsy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_wcount", 32'(wcount), 32'd0);
        rst = 1'b0;
        tick();

        // 1: spaced words with grant always high
        mem_gnt = 1'b1;
        start_run();
        check("t1_bsy_start", 32'(bsy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            send_word(32'hA000_0000 + 32'(i));
            if (i == 0) begin
                check("t1_req_latency", 32'(mem_req), 32'd1);
                check("t1_we_eq_req", 32'(mem_we), 32'd1);
                check("t1_first_data", mem_wdata, 32'hA000_0000);
            end
            ticks(3);
        end
        wait_done();
        check_writes("t1_wr", 8, 32'hA000_0000);
        check("t1_wcount", 32'(wcount), 32'd8);
        check("t1_bsy", 32'(bsy), 32'd0);
        check("t1_ovf", 32'(ovf), 32'd0);
        clear_run();
        check("t1_clr_done", 32'(done), 32'd0);
        check("t1_clr_wcount", 32'(wcount), 32'd0);

        // 2: stalled memory, six words into a four-entry FIFO
        mem_gnt = 1'b0;
        start_run();
        for (int i = 0; i < 6; i++) send_word(32'hB000_0000 + 32'(i));
        ticks(14);
        check("t2_ovf", 32'(ovf), 32'd1);
        check("t2_req_held", 32'(mem_req), 32'd1);
        check("t2_addr_held", 32'(mem_addr), 32'd0);
        check("t2_data_held", mem_wdata, 32'hB000_0000);
        check("t2_no_writes", 32'(wr_addr_q.size()), 32'd0);
        mem_gnt = 1'b1;
        ticks(8);
        check_writes("t2_wr", 4, 32'hB000_0000);
        check("t2_wcount", 32'(wcount), 32'd4);
        check("t2_req_idle", 32'(mem_req), 32'd0);
        check("t2_bsy", 32'(bsy), 32'd1);
        clear_run();

        // 3: full FIFO, grants interleaved with words on grant cycles
        mem_gnt = 1'b0;
        start_run();
        for (int i = 0; i < 4; i++) send_word(32'hC000_0000 + 32'(i));
        for (int k = 0; k < 3; k++) begin
            mem_gnt  = 1'b1;
            in_valid = 1'b1;
            in_data  = 32'hC000_0004 + 32'(k);
            tick();
            mem_gnt  = 1'b0;
            in_valid = 1'b0;
            tick();
        end
        check("t3_ovf_none", 32'(ovf), 32'd0);
        check("t3_req_full", 32'(mem_req), 32'd1);
        check("t3_mid_writes", 32'(wr_addr_q.size()), 32'd3);
        mem_gnt = 1'b1;
        ticks(8);
        check_writes("t3_wr", 7, 32'hC000_0000);
        check("t3_wcount", 32'(wcount), 32'd7);
        check("t3_ovf_end", 32'(ovf), 32'd0);
        clear_run();

        // 4: clear mid-run with pending words, start edge suppressed
        mem_gnt = 1'b0;
        start_run();
        for (int i = 0; i < 6; i++) send_word(32'hD100_0000 + 32'(i));
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("t4_pre_wcount", 32'(wcount), 32'd1);
        check("t4_pre_ovf", 32'(ovf), 32'd1);
        ctrl = 2'b11;
        tick();
        check("t4_clr_bsy", 32'(bsy), 32'd0);
        check("t4_clr_req", 32'(mem_req), 32'd0);
        check("t4_clr_wcount", 32'(wcount), 32'd0);
        check("t4_clr_ovf", 32'(ovf), 32'd0);
        check("t4_clr_wdata", mem_wdata, 32'd0);
        ctrl = 2'b01;
        tick();
        check("t4_held_start", 32'(bsy), 32'd0);
        ctrl = 2'b00;
        tick();
        wr_addr_q.delete();
        wr_data_q.delete();
        mem_gnt = 1'b1;
        start_run();
        check("t4_restart_bsy", 32'(bsy), 32'd1);
        send_word(32'hD000_0000);
        ticks(3);
        check_writes("t4_wr", 1, 32'hD000_0000);
        check("t4_wcount", 32'(wcount), 32'd1);
        clear_run();

        // 5: DONE ignores start edges and words
        mem_gnt = 1'b1;
        start_run();
        for (int i = 0; i < 8; i++) send_word(32'hE000_0000 + 32'(i));
        wait_done();
        check_writes("t5_wr", 8, 32'hE000_0000);
        req_cycles = 0;
        tick();
        start_run();
        for (int i = 0; i < 3; i++) send_word(32'hEE00_0000 + 32'(i));
        ticks(2);
        check("t5_no_req", 32'(req_cycles), 32'd0);
        check("t5_done_held", 32'(done), 32'd1);
        check("t5_bsy", 32'(bsy), 32'd0);
        check("t5_wcount", 32'(wcount), 32'd8);
        check("t5_no_new_writes", 32'(wr_addr_q.size()), 32'd8);
        clear_run();
        start_run();
        check("t5_rerun_bsy", 32'(bsy), 32'd1);
        check("t5_rerun_done", 32'(done), 32'd0);
        clear_run();

        // 6: reset while draining with a pending request
        mem_gnt = 1'b0;
        start_run();
        for (int i = 0; i < 4; i++) send_word(32'hF000_0000 + 32'(i));
        mem_gnt = 1'b1;
        for (int i = 4; i < 8; i++) send_word(32'hF000_0000 + 32'(i));
        mem_gnt = 1'b0;
        check("t6_drain_bsy", 32'(bsy), 32'd1);
        check("t6_drain_req", 32'(mem_req), 32'd1);
        check("t6_drain_done", 32'(done), 32'd0);
        check("t6_drain_wcount", 32'(wcount), 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_req", 32'(mem_req), 32'd0);
        check("t6_rst_we", 32'(mem_we), 32'd0);
        check("t6_rst_addr", 32'(mem_addr), 32'd0);
        check("t6_rst_wdata", mem_wdata, 32'd0);
        check("t6_rst_bsy", 32'(bsy), 32'd0);
        check("t6_rst_done", 32'(done), 32'd0);
        check("t6_rst_ovf", 32'(ovf), 32'd0);
        check("t6_rst_wcount", 32'(wcount), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
